collision_v_arbiter: RTL and testbench

- Parametrised, registered successor to the combinational collision velocity selector.
- Accepts NUM_SRC collision-module requests, each with a candidate next velocity.
- Arbitrates by fixed priority or round-robin, clamps the winner's velocity, holds it for the rest of the frame, and presents it to the ball move module, stable for a whole frame, from each startOfFrame.
- Sits between the per-pair collision modules and the ball move module.

---
 rtl/collision_v_arbiter.sv | 88 ++++++++
 tb/tb_collision_v_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/collision_v_arbiter.sv
// collision_v_arbiter: registered arbiter that picks one collision velocity per frame,
// clamps it, and presents it for the whole following frame.
module collision_v_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int V_WIDTH     = 32,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_SPEED   = 512,
    localparam int IW         = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic [NUM_SRC-1:0]           collision_req,
    input  logic [NUM_SRC*V_WIDTH-1:0]   vx_in,
    input  logic [NUM_SRC*V_WIDTH-1:0]   vy_in,
    output logic                         collision,
    output logic signed [V_WIDTH-1:0]    nxt_vx,
    output logic signed [V_WIDTH-1:0]    nxt_vy,
    output logic [IW-1:0]                grant_idx,
    output logic [7:0]                   drop_cnt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;
    localparam logic signed [V_WIDTH-1:0] MAXV = V_WIDTH'(MAX_SPEED);

    logic [0:0]                state;
    logic [IW-1:0]             rr_ptr, win, hold_idx;
    logic signed [V_WIDTH-1:0] hold_vx, hold_vy;
    logic [7:0]                cnt;
    logic                      found, any_req, capture;
    int                        idx;

    function automatic logic signed [V_WIDTH-1:0] clamp(input logic signed [V_WIDTH-1:0] v);
        return v > MAXV ? MAXV : (v < -MAXV ? -MAXV : v);
    endfunction

    // Search starts at rr_ptr in round-robin mode, at 0 in fixed mode.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = ROUND_ROBIN != 0 ? (int'(rr_ptr) + k) % NUM_SRC : k;
            if (!found && collision_req[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req = |collision_req;
    assign capture = any_req && (state == IDLE || startOfFrame);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            hold_idx  <= '0;
            hold_vx   <= '0;
            hold_vy   <= '0;
            cnt       <= '0;
            collision <= 1'b0;
            nxt_vx    <= '0;
            nxt_vy    <= '0;
            grant_idx <= '0;
            drop_cnt  <= '0;
        end else begin
            if (startOfFrame) begin
                collision <= state == HELD;
                nxt_vx    <= state == HELD ? hold_vx : '0;
                nxt_vy    <= state == HELD ? hold_vy : '0;
                grant_idx <= state == HELD ? hold_idx : '0;
                drop_cnt  <= cnt;
                cnt       <= '0;
            end else if (state == HELD && any_req && cnt != 8'd255) begin
                cnt <= cnt + 8'd1;
            end
            if (capture) begin
                hold_idx <= win;
                hold_vx  <= clamp(vx_in[int'(win)*V_WIDTH +: V_WIDTH]);
                hold_vy  <= clamp(vy_in[int'(win)*V_WIDTH +: V_WIDTH]);
                if (ROUND_ROBIN != 0 && NUM_SRC > 1)
                    rr_ptr <= IW'((int'(win) + 1) % NUM_SRC);
            end
            state <= capture ? HELD : (startOfFrame ? IDLE : state);
        end
    end
endmodule

// File: tb/tb_collision_v_arbiter.sv
// tb_collision_v_arbiter: directed vector table on a fixed-priority instance plus
// hand sequences for round-robin, simultaneous frame/request and mid-frame reset.
module tb_collision_v_arbiter;
    logic         clk = 1'b0, resetN = 1'b0, sof = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] vx_in = '0, vy_in = '0;
    logic         f_coll, r_coll;
    logic signed [31:0] f_vx, f_vy, r_vx, r_vy;
    logic [1:0]   f_idx, r_idx;
    logic [7:0]   f_drop, r_drop;
    int n_vec = 0, n_err = 0;

    collision_v_arbiter #(.NUM_SRC(4), .V_WIDTH(32), .ROUND_ROBIN(0), .MAX_SPEED(512)) dut_fixed (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision_req(req),
        .vx_in(vx_in), .vy_in(vy_in), .collision(f_coll), .nxt_vx(f_vx), .nxt_vy(f_vy),
        .grant_idx(f_idx), .drop_cnt(f_drop));

    collision_v_arbiter #(.NUM_SRC(4), .V_WIDTH(32), .ROUND_ROBIN(1), .MAX_SPEED(512)) dut_rr (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision_req(req),
        .vx_in(vx_in), .vy_in(vy_in), .collision(r_coll), .nxt_vx(r_vx), .nxt_vy(r_vy),
        .grant_idx(r_idx), .drop_cnt(r_drop));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int vxb, vyb, hold;
        logic coll;
        int evx, evy, eidx, edrop;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_end();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        req = '0;
        sof = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    // Source i gets vx = vxb + 100*i and vy = vyb - i.
    task automatic set_v(input int vxb, input int vyb);
        for (int i = 0; i < 4; i++) begin
            vx_in[i*32 +: 32] = 32'(vxb + 100 * i);
            vy_in[i*32 +: 32] = 32'(vyb - i);
        end
    endtask

    task automatic check_fixed(input string tag, input logic c, input int vx, input int vy, input int ix, input int dr);
        check({tag, " coll"}, f_coll, c);
        check({tag, " vx"}, f_vx, vx);
        check({tag, " vy"}, f_vy, vy);
        check({tag, " idx"}, f_idx, ix);
        check({tag, " drop"}, f_drop, dr);
    endtask

    initial begin
        tbl[0] = '{4'b0000,    0,     0,   0, 1'b0,    0,    0, 0,   0};
        tbl[1] = '{4'b0110,  -90,    -2,   1, 1'b1,   10,   -3, 1,   0};
        tbl[2] = '{4'b0001, 1000, -2000,   1, 1'b1,  512, -512, 0,   0};
        tbl[3] = '{4'b1000,    0,     0, 300, 1'b1,  300,   -3, 3, 255};
        tbl[4] = '{4'b0000,    0,     0,   0, 1'b0,    0,    0, 0,   0};
        tbl[5] = '{4'b0100,    5,     5,   3, 1'b1,  205,    3, 2,   2};
        tbl[6] = '{4'b0010,  413,  -512,   1, 1'b1,  512, -512, 1,   0};
        tbl[7] = '{4'b0001,  512,  -512,   1, 1'b1,  512, -512, 0,   0};
        tbl[8] = '{4'b1001, -511,     7,   2, 1'b1, -511,    7, 0,   1};

        do_reset();
        check_fixed("reset", 1'b0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            set_v(tbl[i].vxb, tbl[i].vyb);
            for (int c = 0; c < tbl[i].hold; c++) begin
                req = tbl[i].req;
                tick();
            end
            req = '0;
            tick();
            frame_end();
            check_fixed($sformatf("v%0d", i), tbl[i].coll, tbl[i].evx, tbl[i].evy, tbl[i].eidx, tbl[i].edrop);
        end

        // Round-robin: 4'b1001 each frame grants 0, 3, 0.
        do_reset();
        set_v(0, 0);
        for (int f = 0; f < 3; f++) begin
            req = 4'b1001;
            tick();
            req = '0;
            tick();
            frame_end();
            check($sformatf("rr f%0d idx", f), r_idx, (f == 1) ? 3 : 0);
            check($sformatf("rr f%0d coll", f), r_coll, 1);
            check($sformatf("rr f%0d drop", f), r_drop, 0);
        end

        // Frame strobe coinciding with a new request.
        do_reset();
        set_v(0, 0);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        req = 4'b1000;
        frame_end();
        req = '0;
        check("sim k+1 idx", f_idx, 2);
        check("sim k+1 vx", f_vx, 200);
        check("sim k+1 drop", f_drop, 0);
        tick();
        tick();
        check("sim stable idx", f_idx, 2);
        frame_end();
        check("sim k+2 idx", f_idx, 3);
        check("sim k+2 vx", f_vx, 300);
        check("sim k+2 coll", f_coll, 1);
        check("sim k+2 drop", f_drop, 0);

        // Reset asserted while HELD with nonzero outputs.
        set_v(7, 0);
        req = 4'b0001;
        tick();
        req = '0;
        frame_end();
        check("pre-rst coll", f_coll, 1);
        req = 4'b0010;
        tick();
        req = '0;
        #2 resetN = 1'b0;
        #1;
        check("async rst coll", f_coll, 0);
        check("async rst vx", f_vx, 0);
        check("async rst idx", f_idx, 0);
        tick();
        resetN = 1'b1;
        tick();
        frame_end();
        check("post-rst coll", f_coll, 0);
        check("post-rst vx", f_vx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
